// File: rtl/fsk_pkg.sv
// Shared types and helpers for the FSK receive chain: frame FSM states,
// parity helper and the default bit period used across the demodulator.
package fsk_pkg;

  localparam int FSK_BIT_CYCLES = 1024;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  // Zero-extension to 9 bits does not change the XOR reduction.
  function automatic logic parity_of(input logic [8:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/fsk_bit_timer.sv
// Bit-period counter for the frame receiver: ticks at the half-bit or
// full-bit terminal count and wraps so consecutive bits stay aligned.
module fsk_bit_timer #(
  parameter int BIT_CYCLES = 1024
) (
  input  logic clk,
  input  logic as_reset_n,
  input  logic clear,
  input  logic half,
  output logic tick
);

  localparam int CNT_W = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYCLES / 2 - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge as_reset_n) begin
    if (!as_reset_n) begin
      cnt <= '0;
    end else if (clear || cnt == FULL_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == (half ? HALF_LAST : FULL_LAST));

endmodule

// File: rtl/fsk_frame_rx.sv
// Asynchronous serial frame receiver behind the FSK demodulator: start,
// LSB-first data, optional parity, one stop bit, single-entry output register.
module fsk_frame_rx
  import fsk_pkg::*;
#(
  parameter int BIT_CYCLES = FSK_BIT_CYCLES,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 as_reset_n,
  input  logic                 carrier_present,
  input  logic                 rx_bit,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 carrier_err,
  output logic                 busy
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic PAR_EN  = (PARITY_EN != 0);
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  rx_state_t            state, state_n;
  logic                 tick;
  logic                 deliver;
  logic                 frame_bad;
  logic                 lost;
  logic [DATA_BITS-1:0] shreg;
  logic [IDX_W-1:0]     idx;
  logic                 perr_q;

  fsk_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .as_reset_n(as_reset_n),
    .clear     (state_n != state),
    .half      (state == START),
    .tick      (tick)
  );

  always_ff @(posedge clk or negedge as_reset_n) begin
    if (!as_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Carrier loss outranks any sample taken in the same cycle.
  always_comb begin
    state_n   = state;
    deliver   = 1'b0;
    frame_bad = 1'b0;
    lost      = 1'b0;
    case (state)
      IDLE: begin
        if (carrier_present && !rx_bit) state_n = START;
      end
      START: begin
        if (!carrier_present) begin
          state_n = IDLE;
          lost    = 1'b1;
        end else if (tick) begin
          state_n = rx_bit ? IDLE : DATA;
        end
      end
      DATA: begin
        if (!carrier_present) begin
          state_n = IDLE;
          lost    = 1'b1;
        end else if (tick && idx == IDX_LAST) begin
          state_n = PAR_EN ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (!carrier_present) begin
          state_n = IDLE;
          lost    = 1'b1;
        end else if (tick) begin
          state_n = STOP;
        end
      end
      STOP: begin
        if (!carrier_present) begin
          state_n = IDLE;
          lost    = 1'b1;
        end else if (tick) begin
          if (rx_bit) begin
            deliver = 1'b1;
            state_n = IDLE;
          end else begin
            frame_bad = 1'b1;
            state_n   = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (!carrier_present || rx_bit) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign carrier_err = lost;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge as_reset_n) begin
    if (!as_reset_n) begin
      shreg  <= '0;
      idx    <= '0;
      perr_q <= 1'b0;
    end else begin
      if (state == DATA && carrier_present && tick) begin
        shreg <= {rx_bit, shreg[DATA_BITS-1:1]};
        idx   <= idx + 1'b1;
      end else if (state != DATA) begin
        idx <= '0;
      end
      if (state == PARITY && carrier_present && tick) begin
        perr_q <= ((parity_of(9'(shreg)) ^ rx_bit) != PAR_ODD);
      end else if (state == START) begin
        perr_q <= 1'b0;
      end
    end
  end

  // Output register: hold the pending word until accepted, drop newcomers.
  always_ff @(posedge clk or negedge as_reset_n) begin
    if (!as_reset_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= frame_bad;
      overrun   <= 1'b0;
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          parity_err <= perr_q;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fsk_frame_rx.sv
// Scoreboard bench for fsk_frame_rx with a 16-cycle bit period: stimulus
// queues expected words and pulses, an independent monitor pops and compares.
module tb_fsk_frame_rx;

  logic       clk;
  logic       as_reset_n;
  logic       carrier_present;
  logic       rx_bit;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       carrier_err;
  logic       busy;

  int cyc = 0;
  int n_total = 0;
  int n_pass = 0;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    int         at;
  } exp_t;

  typedef struct {
    int kind;
    int at;
  } pulse_t;

  exp_t   exp_q[$];
  pulse_t pulse_q[$];

  fsk_frame_rx #(
    .BIT_CYCLES(16),
    .DATA_BITS (8),
    .PARITY_EN (1),
    .PARITY_ODD(0)
  ) dut (
    .clk            (clk),
    .as_reset_n     (as_reset_n),
    .carrier_present(carrier_present),
    .rx_bit         (rx_bit),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .parity_err     (parity_err),
    .frame_err      (frame_err),
    .overrun        (overrun),
    .carrier_err    (carrier_err),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp_v);
    n_total++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
  endtask

  task automatic hold(input logic b, input int n);
    rx_bit = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    hold(1'b0, 16);
    for (int i = 0; i < 8; i++) hold(d[i], 16);
    hold(p, 16);
    hold(s, 16);
  endtask

  task automatic push_word(input logic [7:0] d, input logic p, input int at);
    exp_t e;
    e.data = d;
    e.perr = p;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic push_pulse(input int kind, input int at);
    pulse_t e;
    e.kind = kind;
    e.at   = at;
    pulse_q.push_back(e);
  endtask

  // Monitor: words on handshake, pulses whenever any is high.
  initial begin
    exp_t   e;
    pulse_t p;
    logic [2:0] pl;
    forever begin
      @(negedge clk);
      #1;
      if (as_reset_n) begin
        if (rx_valid && rx_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("word_data", int'(rx_data), int'(e.data));
            check("word_parity_err", int'(parity_err), int'(e.perr));
            if (e.at >= 0) check("word_cycle", cyc, e.at);
          end
        end
        pl = {carrier_err, overrun, frame_err};
        for (int k = 0; k < 3; k++) begin
          if (pl[k]) begin
            if (pulse_q.size() == 0) begin
              check("unexpected_pulse_kind", k, -1);
            end else begin
              p = pulse_q.pop_front();
              check("pulse_kind", k, p.kind);
              check("pulse_cycle", cyc, p.at);
            end
          end
        end
      end
    end
  end

  initial begin
    int t;
    logic [10:0] fv;
    as_reset_n      = 1'b0;
    carrier_present = 1'b1;
    rx_bit          = 1'b1;
    rx_ready        = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rx_valid", int'(rx_valid), 0);
    check("reset_rx_data", int'(rx_data), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_pulses", int'({frame_err, overrun, carrier_err, parity_err}), 0);
    as_reset_n = 1'b1;
    hold(1'b1, 5);

    // Clean frame 0xA5, even parity bit 0
    t = cyc;
    push_word(8'hA5, 1'b0, t + 169);
    send_frame(8'hA5, 1'b0, 1'b1);
    hold(1'b1, 10);

    // Short glitch rejected at the half-bit sample
    t = cyc;
    rx_bit = 1'b0;
    @(negedge clk);
    check("glitch_busy_t1", int'(busy), 1);
    repeat (3) @(negedge clk);
    rx_bit = 1'b1;
    repeat (4) @(negedge clk);
    check("glitch_busy_t8", int'(busy), 1);
    @(negedge clk);
    check("glitch_idle_t9", int'(busy), 0);
    hold(1'b1, 10);

    // Wrong parity bit
    t = cyc;
    push_word(8'h3C, 1'b1, t + 169);
    send_frame(8'h3C, 1'b1, 1'b1);
    hold(1'b1, 10);

    // Stop bit 0 then break: frame_err, WAIT_IDLE until line returns high
    t = cyc;
    push_pulse(0, t + 169);
    send_frame(8'h55, 1'b0, 1'b0);
    hold(1'b0, 40);
    check("break_busy_held", int'(busy), 1);
    rx_bit = 1'b1;
    @(negedge clk);
    check("break_busy_released", int'(busy), 0);
    hold(1'b1, 10);

    // Back-to-back frames with consumer stalled: second word overruns
    rx_ready = 1'b0;
    push_word(8'h11, 1'b0, -1);
    send_frame(8'h11, 1'b0, 1'b1);
    t = cyc;
    push_pulse(1, t + 169);
    send_frame(8'h22, 1'b0, 1'b1);
    hold(1'b1, 5);
    check("stall_valid", int'(rx_valid), 1);
    check("stall_data_kept", int'(rx_data), 8'h11);
    rx_ready = 1'b1;
    @(negedge clk);
    check("stall_valid_dropped", int'(rx_valid), 0);
    hold(1'b1, 10);

    // Carrier loss inside DATA
    fv = {1'b1, 1'b0, 8'h5A, 1'b0};
    t = cyc;
    push_pulse(2, t + 50);
    for (int c = 0; c < 50; c++) begin
      rx_bit = fv[c / 16];
      @(negedge clk);
    end
    rx_bit = fv[3];
    carrier_present = 1'b0;
    @(negedge clk);
    check("carrier_busy_cleared", int'(busy), 0);
    check("carrier_no_valid", int'(rx_valid), 0);
    carrier_present = 1'b1;
    hold(1'b1, 10);

    // Asynchronous reset mid-frame
    for (int c = 0; c < 50; c++) begin
      rx_bit = fv[c / 16];
      @(negedge clk);
    end
    check("pre_reset_busy", int'(busy), 1);
    as_reset_n = 1'b0;
    rx_bit     = 1'b1;
    #1;
    check("midreset_busy", int'(busy), 0);
    check("midreset_rx_data", int'(rx_data), 0);
    check("midreset_rx_valid", int'(rx_valid), 0);
    check("midreset_pulses", int'({frame_err, overrun, carrier_err, parity_err}), 0);
    @(negedge clk);
    as_reset_n = 1'b1;
    hold(1'b1, 20);

    check("words_outstanding", exp_q.size(), 0);
    check("pulses_outstanding", pulse_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fsk_frame_rx.md
Name: fsk_frame_rx

Overview:
Downstream stage of the FSK period demodulator. Consumes the demodulated bit stream (logic level plus carrier-present flag) and recovers asynchronous serial frames: start bit, DATA_BITS data bits LSB-first, optional parity bit, one stop bit. Delivers each received byte over a valid/ready interface with error sideband and one-cycle error pulses.

Parameters:
BIT_CYCLES, 1024, clk cycles per bit; even, >= 4.
DATA_BITS, 8, data bits per frame; 5..9.
PARITY_EN, 1, 1 = parity bit present after data.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored if PARITY_EN=0.

Ports:
clk  in  1  clock
as_reset_n  in  1  reset, asynchronous, active-low
carrier_present  in  1  demodulator carrier flag; already registered in clk domain
rx_bit  in  1  demodulated line level; idle/mark = 1; already registered in clk domain
rx_data  out  DATA_BITS  received data word
rx_valid  out  1  rx_data/parity_err valid
rx_ready  in  1  consumer accepts word
parity_err  out  1  sideband of rx_data; qualified by rx_valid
frame_err  out  1  1-cycle pulse: stop bit sampled 0
overrun  out  1  1-cycle pulse: completed word dropped
carrier_err  out  1  1-cycle pulse: carrier lost mid-frame
busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, shift register 0.
- No input synchronisers; inputs are used directly.
- Bit counter width $clog2(BIT_CYCLES). It clears on every state change and counts up otherwise.
- IDLE: when carrier_present=1 and rx_bit=0 (cycle t), go to START at t+1 with cnt=0.
- START: when cnt = BIT_CYCLES/2-1 (cycle t+BIT_CYCLES/2), sample rx_bit.
  - Sample 0: go to DATA, bit index 0.
  - Sample 1: treat as a glitch and return to IDLE with no pulse.
- DATA: sample when cnt = BIT_CYCLES-1 (mid-bit) and shift the sample in LSB-first. After DATA_BITS samples, go to PARITY if PARITY_EN, else STOP.
- PARITY: sample at the same point as DATA. parity_err_next = XOR(data, sampled bit) != PARITY_ODD.
- STOP: sample at the same point as DATA.
  - Sample 1: deliver word, go to IDLE.
  - Sample 0: pulse frame_err, no delivery, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_bit=1, then go to IDLE. This prevents a break condition from retriggering.
- Stop-bit sample cycle = t + BIT_CYCLES/2 + (DATA_BITS+PARITY_EN+1)*BIT_CYCLES. rx_valid rises the next cycle.
- Output register (1 entry):
  - Delivery with rx_valid=0, or with rx_valid=1 and rx_ready=1 in the same cycle: load rx_data/parity_err and set rx_valid=1.
  - Delivery with rx_valid=1 and rx_ready=0: keep the old word, drop the new one, pulse overrun.
  - rx_valid=1, rx_ready=1, no delivery: clear rx_valid.
  - rx_data and parity_err stay stable while rx_valid=1 and rx_ready=0.
- Carrier loss in START/DATA/PARITY/STOP (carrier_present=0 on any cycle): abort to IDLE, pulse carrier_err, no delivery, discard partial word.
- Carrier loss in WAIT_IDLE: go to IDLE with no pulse.
- Carrier loss in IDLE: no effect.
- Priority within one cycle: carrier loss > sampling. The output handshake runs independently of the frame FSM.
- Reset mid-frame: immediate return to reset values; a partially received word is lost.

Decomposition:
- Package fsk_pkg:
  - Enum rx_state_t {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE}.
  - Function for parity computation.
  - Shared default constant FSK_BIT_CYCLES, used with the demodulator's counter limits.
- Sub-module fsk_bit_timer:
  - Parameterised BIT_CYCLES counter.
  - Inputs: clear, half (select half-bit terminal).
  - Output: tick at the terminal count.
- The FSM, shift register and output register stay in fsk_frame_rx.

Test Plan:
All scenarios use BIT_CYCLES=16, DATA_BITS=8, PARITY_EN=1, PARITY_ODD=0, carrier_present=1, rx_ready=1 unless stated. t = cycle rx_bit first goes 0.
1. Frame 0xA5, parity 0, stop 1 -> rx_valid high exactly 1 cycle at t+169; rx_data=0xA5; parity_err=0; no pulses.
2. rx_bit low for 4 cycles only -> busy high t+1..t+8, IDLE at t+9; no rx_valid, no pulses.
3. Frame 0x3C with parity bit 1 (wrong) -> rx_data=0x3C with parity_err=1 at t+169.
4. Frame 0x55 with stop bit 0, line held 0 for 40 more cycles -> frame_err pulse at t+169; no rx_valid; busy stays 1 until the cycle after rx_bit returns 1.
5. rx_ready=0; frames 0x11 then 0x22 back-to-back -> rx_valid=1 with 0x11; overrun pulse on the 0x22 stop sample; rx_data stays 0x11. Then set rx_ready=1 -> rx_valid drops the next cycle.
6. Drop carrier_present at t+50 (in DATA) -> carrier_err pulse at t+50; busy=0 at t+51; no rx_valid. Repeat with as_reset_n pulsed low at t+50 -> all outputs 0 immediately.
